// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types and helpers for the CPU/loader memory port arbiter.
//   state_e : arbiter FSM state encodings
//   owner_e : which requester owns the current access
package mem_port_arbiter_pkg;

   localparam int unsigned AW_DEF   = 8;
   localparam int unsigned DW_DEF   = 16;
   localparam int unsigned WAIT_MAX = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_EXT = 1'b1
   } owner_e;

   // Wait counter width; at least one bit even when no wait states are used.
   function automatic int unsigned cnt_width(input int unsigned wait_cycles);
      return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the CPU side, loader (ext) side and memory side of the arbiter.
//   slave  : arbiter view (takes requests, drives acks and the memory)
//   master : environment view (drives requests, returns memory read data)
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 16
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;

   logic          ext_req;
   logic          ext_lock;
   logic          ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
   logic          ext_ack;
   logic [DW-1:0] ext_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          grant_ext;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata, cpu_stall,
      input  ext_req, ext_lock, ext_we, ext_addr, ext_wdata,
      output ext_ack, ext_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, grant_ext,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata, cpu_stall,
      output ext_req, ext_lock, ext_we, ext_addr, ext_wdata,
      input  ext_ack, ext_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, grant_ext,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Purpose: two-requester round-robin arbiter with a sticky lock for the ext port.
//   req_i      : {ext_req, cpu_req}
//   lock_i     : ext_lock
//   last_win_i : owner of the previous grant
//   win_c_o    : selected owner (combinational)
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       lock_i,
   input  owner_e     last_win_i,
   output owner_e     win_c_o
);

   // Lock only holds the grant for ext if ext won last time and still asks.
   always_comb begin
      win_c_o = OWN_CPU;
      if (lock_i && (last_win_i == OWN_EXT) && req_i[1]) begin
         win_c_o = OWN_EXT;
      end else if (&req_i) begin
         win_c_o = owner_e'(~last_win_i);
      end else if (req_i[1]) begin
         win_c_o = OWN_EXT;
      end else begin
         win_c_o = OWN_CPU;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one synchronous single-port memory between the CPU controller
//   and the external loader/debug port, with WAIT_CYCLES extra memory cycles.
//   clk, rst_n : clock and asynchronous active-low reset
//   port_if    : CPU req/ack, ext req/ack/lock, memory strobe/address/data, grant status
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned AW          = AW_DEF,
   parameter int unsigned DW          = DW_DEF,
   parameter int unsigned WAIT_CYCLES = 0
)(
   input  logic           clk,
   input  logic           rst_n,
   mem_port_arbiter_if.slave port_if
);

   localparam int unsigned CW      = cnt_width(WAIT_CYCLES);
   localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES);

   state_e        state_q,     state_d;
   owner_e        owner_q,     owner_d;
   owner_e        last_win_q,  last_win_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          we_q,        we_d;
   logic          mem_en_q,    mem_en_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          cpu_ack_q,   cpu_ack_d;
   logic          ext_ack_q,   ext_ack_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] ext_rdata_q, ext_rdata_d;
   logic          grant_ext_q, grant_ext_d;

   owner_e        win_c;

   rr_arb2 u_arb (
      .req_i      ({port_if.ext_req, port_if.cpu_req}),
      .lock_i     (port_if.ext_lock),
      .last_win_i (last_win_q),
      .win_c_o    (win_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_win_d  = last_win_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_ack_d   = 1'b0;
      ext_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      ext_rdata_d = ext_rdata_q;
      grant_ext_d = grant_ext_q;

      unique case (state_q)
         ST_IDLE: begin
            if (port_if.cpu_req || port_if.ext_req) begin
               // Only the granted request's fields are captured; later changes are ignored.
               owner_d     = win_c;
               last_win_d  = win_c;
               grant_ext_d = (win_c == OWN_EXT);
               if (win_c == OWN_EXT) begin
                  we_d        = port_if.ext_we;
                  mem_addr_d  = port_if.ext_addr;
                  mem_wdata_d = port_if.ext_wdata;
               end else begin
                  we_d        = port_if.cpu_we;
                  mem_addr_d  = port_if.cpu_addr;
                  mem_wdata_d = port_if.cpu_wdata;
               end
               mem_we_d = we_d;
               mem_en_d = 1'b1;
               cnt_d    = WAIT_LD;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               mem_en_d = 1'b0;
               state_d  = ST_RESP;
               if (owner_q == OWN_EXT) begin
                  ext_ack_d = 1'b1;
                  if (!we_q) ext_rdata_d = port_if.mem_rdata;
               end else begin
                  cpu_ack_d = 1'b1;
                  if (!we_q) cpu_rdata_d = port_if.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_RESP: begin
            grant_ext_d = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_CPU;
         last_win_q  <= OWN_EXT;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         ext_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
         grant_ext_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_win_q  <= last_win_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         ext_ack_q   <= ext_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         ext_rdata_q <= ext_rdata_d;
         grant_ext_q <= grant_ext_d;
      end
   end

   assign port_if.mem_en    = mem_en_q;
   assign port_if.mem_we    = mem_we_q;
   assign port_if.mem_addr  = mem_addr_q;
   assign port_if.mem_wdata = mem_wdata_q;
   assign port_if.cpu_ack   = cpu_ack_q;
   assign port_if.ext_ack   = ext_ack_q;
   assign port_if.cpu_rdata = cpu_rdata_q;
   assign port_if.ext_rdata = ext_rdata_q;
   assign port_if.grant_ext = grant_ext_q;

   // Lets the controller freeze its stage clock until the ack arrives.
   assign port_if.cpu_stall = port_if.cpu_req & ~cpu_ack_q;

endmodule
